// File: rtl/hdmi_frame_checker_pkg.sv
// rtl/hdmi_frame_checker_pkg.sv - shared state encoding and capture word layout
// Field offsets describe {R,G,B,h,v,ts} as written by the capture FIFO.
package hdmi_frame_checker_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

  localparam int R_MSB  = 71;
  localparam int R_LSB  = 64;
  localparam int G_MSB  = 63;
  localparam int G_LSB  = 56;
  localparam int B_MSB  = 55;
  localparam int B_LSB  = 48;
  localparam int H_MSB  = 47;
  localparam int H_LSB  = 36;
  localparam int V_MSB  = 35;
  localparam int V_LSB  = 24;
  localparam int TS_MSB = 23;
  localparam int TS_LSB = 0;

  // Test pattern: R carries the column, G the line, B their XOR.
  function automatic logic [23:0] exp_pixel(input logic [11:0] h, input logic [11:0] v);
    return {h[7:0], v[7:0], h[7:0] ^ v[7:0]};
  endfunction

endpackage

// File: rtl/hdmi_frame_checker_sat_cnt16.sv
// rtl/hdmi_frame_checker_sat_cnt16.sv - 16-bit saturating event counter
// Clear wins over a simultaneous increment.
module sat_cnt16
  import hdmi_frame_checker_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] q
);

  logic [15:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != 16'hFFFF)) begin
      r_q <= r_q + 16'd1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/hdmi_frame_checker.sv
// rtl/hdmi_frame_checker.sv - capture-stream frame checker
// Locks to h=0,v=0, then follows the raster and counts coordinate and pattern errors.
module hdmi_frame_checker
  import hdmi_frame_checker_pkg::*;
#(
  parameter logic [11:0] H_TOTAL    = 12'd1920,
  parameter logic [11:0] V_TOTAL    = 12'd1080,
  parameter logic        PATTERN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [71:0] fifo_dout,
  input  logic        fifo_empty,
  input  logic        fifo_valid,
  output logic        fifo_rd_en,
  input  logic        stat_clr,
  output logic        locked,
  output logic [15:0] frame_cnt,
  output logic [15:0] coord_err_cnt,
  output logic [15:0] pix_err_cnt,
  output logic [23:0] frame_period,
  output logic        frame_done
);

  state_t      r_state, w_state_nxt;
  logic [11:0] r_exp_h, w_exp_h_nxt;
  logic [11:0] r_exp_v, w_exp_v_nxt;
  logic [23:0] r_start_ts, w_start_ts_nxt;
  logic [23:0] r_frame_period, w_frame_period_nxt;
  logic [15:0] r_frame_cnt, w_frame_cnt_nxt;
  logic        r_frame_done, w_frame_done_nxt;
  logic        w_coord_inc, w_pix_inc, w_lock;

  logic [11:0] w_h, w_v;
  logic [23:0] w_ts, w_rgb;
  logic        w_origin, w_coord_ok, w_last, w_pix_ok;

  assign w_h        = fifo_dout[H_MSB:H_LSB];
  assign w_v        = fifo_dout[V_MSB:V_LSB];
  assign w_ts       = fifo_dout[TS_MSB:TS_LSB];
  assign w_rgb      = {fifo_dout[R_MSB:R_LSB], fifo_dout[G_MSB:G_LSB], fifo_dout[B_MSB:B_LSB]};
  assign w_origin   = (w_h == 12'd0) && (w_v == 12'd0);
  assign w_coord_ok = (w_h == r_exp_h) && (w_v == r_exp_v);
  assign w_last     = (w_h == H_TOTAL - 12'd1) && (w_v == V_TOTAL - 12'd1);
  assign w_pix_ok   = (w_rgb == exp_pixel(w_h, w_v));

  always_comb begin
    w_state_nxt        = r_state;
    w_exp_h_nxt        = r_exp_h;
    w_exp_v_nxt        = r_exp_v;
    w_start_ts_nxt     = r_start_ts;
    w_frame_period_nxt = r_frame_period;
    w_frame_cnt_nxt    = r_frame_cnt;
    w_frame_done_nxt   = 1'b0;
    w_coord_inc        = 1'b0;
    w_pix_inc          = 1'b0;
    w_lock             = 1'b0;
    if (fifo_valid) begin
      case (r_state)
        ST_HUNT, ST_RESYNC: w_lock = w_origin;
        ST_CHECK: begin
          if (w_coord_ok) begin
            w_pix_inc = PATTERN_EN && !w_pix_ok;
            if (w_origin) begin
              w_frame_period_nxt = w_ts - r_start_ts;
              w_start_ts_nxt     = w_ts;
            end
            if (w_last) begin
              w_frame_done_nxt = 1'b1;
              w_frame_cnt_nxt  = r_frame_cnt + 16'd1;
              w_exp_h_nxt      = 12'd0;
              w_exp_v_nxt      = 12'd0;
            end else if (r_exp_h == H_TOTAL - 12'd1) begin
              w_exp_h_nxt = 12'd0;
              w_exp_v_nxt = r_exp_v + 12'd1;
            end else begin
              w_exp_h_nxt = r_exp_h + 12'd1;
            end
          end else begin
            // A mismatching frame start is itself a valid lock point.
            w_coord_inc = 1'b1;
            w_lock      = w_origin;
            if (!w_origin) w_state_nxt = ST_RESYNC;
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
      if (w_lock) begin
        w_state_nxt     = ST_CHECK;
        w_start_ts_nxt  = w_ts;
        w_exp_h_nxt     = 12'd1;
        w_exp_v_nxt     = 12'd0;
        w_frame_cnt_nxt = 16'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_HUNT;
      r_exp_h        <= '0;
      r_exp_v        <= '0;
      r_start_ts     <= '0;
      r_frame_period <= '0;
      r_frame_cnt    <= '0;
      r_frame_done   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_exp_h        <= w_exp_h_nxt;
      r_exp_v        <= w_exp_v_nxt;
      r_start_ts     <= w_start_ts_nxt;
      r_frame_period <= w_frame_period_nxt;
      r_frame_cnt    <= w_frame_cnt_nxt;
      r_frame_done   <= w_frame_done_nxt;
    end
  end

  sat_cnt16 u_coord_err (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_coord_inc),
    .clr   (stat_clr),
    .q     (coord_err_cnt)
  );

  sat_cnt16 u_pix_err (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_pix_inc),
    .clr   (stat_clr),
    .q     (pix_err_cnt)
  );

  assign fifo_rd_en   = rst_n & ~fifo_empty;
  assign locked       = (r_state == ST_CHECK);
  assign frame_cnt    = r_frame_cnt;
  assign frame_period = r_frame_period;
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_hdmi_frame_checker.sv
// tb/tb_hdmi_frame_checker.sv - scoreboard bench for hdmi_frame_checker on a 4x2 raster
// A FIFO emulator feeds both a pattern-checking and a pattern-blind instance.
module tb_hdmi_frame_checker;

  localparam int NH = 4;
  localparam int NV = 2;
  localparam int NPIX = NH * NV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [71:0] fifo_dout = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_valid = 1'b0;
  logic        stat_clr = 1'b0;

  logic        fifo_rd_en, locked, frame_done;
  logic [15:0] frame_cnt, coord_err_cnt, pix_err_cnt;
  logic [23:0] frame_period;
  logic        np_rd_en, np_locked, np_frame_done;
  logic [15:0] np_frame_cnt, np_coord_err_cnt, np_pix_err_cnt;
  logic [23:0] np_frame_period;

  always #5 clk = ~clk;

  hdmi_frame_checker #(.H_TOTAL(12'd4), .V_TOTAL(12'd2), .PATTERN_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_valid(fifo_valid), .fifo_rd_en(fifo_rd_en), .stat_clr(stat_clr),
    .locked(locked), .frame_cnt(frame_cnt), .coord_err_cnt(coord_err_cnt),
    .pix_err_cnt(pix_err_cnt), .frame_period(frame_period), .frame_done(frame_done)
  );

  hdmi_frame_checker #(.H_TOTAL(12'd4), .V_TOTAL(12'd2), .PATTERN_EN(1'b0)) dut_np (
    .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_valid(fifo_valid), .fifo_rd_en(np_rd_en), .stat_clr(stat_clr),
    .locked(np_locked), .frame_cnt(np_frame_cnt), .coord_err_cnt(np_coord_err_cnt),
    .pix_err_cnt(np_pix_err_cnt), .frame_period(np_frame_period), .frame_done(np_frame_done)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int done_pulses = 0;

  logic [72:0] src_q[$];
  int          stall_pct = 0;
  bit          clr_req = 1'b0;

  typedef struct {
    logic [15:0] fcnt;
    logic [15:0] cerr;
    logic [15:0] perr;
    logic [23:0] period;
  } rec_t;
  rec_t sb_q[$];

  bit          m_locked, m_done_pend;
  int          m_pos;
  logic [15:0] m_fcnt, m_cerr, m_perr;
  logic [23:0] m_start, m_period;

  bit          s_locked, s_done;
  logic [15:0] s_fcnt, s_cerr, s_perr;
  logic [23:0] s_period;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] mk(input logic [11:0] h, input logic [11:0] v, input logic [23:0] ts);
    return {h[7:0], v[7:0], h[7:0] ^ v[7:0], h, v, ts};
  endfunction

  function automatic void model_reset();
    m_locked = 0; m_done_pend = 0; m_pos = 0;
    m_fcnt = 0; m_cerr = 0; m_perr = 0; m_start = 0; m_period = 0;
  endfunction

  // Reference: position in the frame is a linear pixel index; h/v follow from it.
  function automatic bit model_word(input logic [71:0] w);
    logic [11:0] hh, vv;
    logic [23:0] ts;
    bit          origin;
    hh = w[47:36]; vv = w[35:24]; ts = w[23:0];
    origin = (hh == 0) && (vv == 0);
    if (!m_locked) begin
      if (origin) begin
        m_locked = 1; m_pos = 1; m_start = ts; m_fcnt = 0;
      end
      return 0;
    end
    if (int'(hh) == m_pos % NH && int'(vv) == m_pos / NH) begin
      if (w[71:64] != hh[7:0] || w[63:56] != vv[7:0] || w[55:48] != (hh[7:0] ^ vv[7:0]))
        if (m_perr != 16'hFFFF) m_perr++;
      if (origin) begin
        m_period = ts - m_start; m_start = ts;
      end
      m_pos++;
      if (m_pos == NPIX) begin
        m_pos = 0; m_fcnt = m_fcnt + 16'd1;
        return 1;
      end
      return 0;
    end
    if (m_cerr != 16'hFFFF) m_cerr++;
    if (origin) begin
      m_pos = 1; m_start = ts; m_fcnt = 0;
    end else begin
      m_locked = 0;
    end
    return 0;
  endfunction

  // FIFO emulator: data appears the cycle after rd_en is seen, modelled at that moment.
  initial begin : driver
    logic        rd;
    logic [72:0] e;
    bit          done;
    forever begin
      @(posedge clk);
      s_locked = m_locked; s_fcnt = m_fcnt; s_cerr = m_cerr; s_perr = m_perr;
      s_period = m_period; s_done = m_done_pend;
      rd = fifo_rd_en;
      #1;
      done = 0;
      fifo_valid = 1'b0;
      stat_clr = clr_req;
      clr_req = 1'b0;
      if (rd && src_q.size() > 0) begin
        e = src_q.pop_front();
        fifo_dout = e[71:0];
        fifo_valid = 1'b1;
        stat_clr = stat_clr | e[72];
        done = model_word(e[71:0]);
      end else begin
        fifo_dout = ($urandom_range(1) == 1) ? mk(12'd0, 12'd0, 24'($urandom))
                                              : {8'($urandom), 32'($urandom), 32'($urandom)};
      end
      if (stat_clr && rst_n) begin
        m_cerr = 0; m_perr = 0;
      end
      m_done_pend = done;
      if (done) sb_q.push_back('{m_fcnt, m_cerr, m_perr, m_period});
      fifo_empty = (src_q.size() == 0) || ($urandom_range(99) < stall_pct);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rd_en", fifo_rd_en, 32'(!fifo_empty));
      chk("np_rd_en", np_rd_en, 32'(!fifo_empty));
      chk("locked", locked, s_locked);
      chk("frame_cnt", frame_cnt, s_fcnt);
      chk("coord_err_cnt", coord_err_cnt, s_cerr);
      chk("pix_err_cnt", pix_err_cnt, s_perr);
      chk("frame_period", frame_period, s_period);
      chk("frame_done", frame_done, s_done);
      chk("np_locked", np_locked, s_locked);
      chk("np_frame_cnt", np_frame_cnt, s_fcnt);
      chk("np_coord_err_cnt", np_coord_err_cnt, s_cerr);
      chk("np_pix_err_cnt", np_pix_err_cnt, 0);
      chk("np_frame_period", np_frame_period, s_period);
      chk("np_frame_done", np_frame_done, s_done);
      if (frame_done) begin
        done_pulses++;
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_done", 1, 0);
        end else begin
          rec_t r;
          r = sb_q.pop_front();
          chk("sb_frame_cnt", frame_cnt, r.fcnt);
          chk("sb_coord_err", coord_err_cnt, r.cerr);
          chk("sb_pix_err", pix_err_cnt, r.perr);
          chk("sb_period", frame_period, r.period);
        end
      end
    end
  end

  task automatic push_frame(input int first, input int last, input int drop, input int bad,
                            input logic [23:0] mask, input logic [23:0] ts0);
    logic [71:0] w;
    for (int i = first; i <= last; i++) begin
      if (i != drop) begin
        w = mk(12'(i % NH), 12'(i / NH), ts0 + 24'(i));
        if (i == bad) w[71:48] = w[71:48] ^ mask;
        src_q.push_back({1'b0, w});
      end
    end
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (src_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    chk("drain_done", 32'(src_q.size()), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_coord_err", coord_err_cnt, 0);
    chk("rst_pix_err", pix_err_cnt, 0);
    chk("rst_period", frame_period, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [71:0] w;
    logic [23:0] g_ts;
    int          first, drop, bad;
    logic [23:0] mask;
    model_reset();

    // Mid-frame words queued while in reset; they must be discarded after release.
    src_q.push_back({1'b0, mk(12'd2, 12'd1, 24'h000100)});
    src_q.push_back({1'b0, mk(12'd3, 12'd1, 24'h000101)});
    do_reset();
    push_frame(0, 7, -1, -1, 24'h0, 24'h001000);
    push_frame(0, 7, -1, -1, 24'h0, 24'h001008);
    push_frame(0, 7, -1, -1, 24'h0, 24'h001010);
    drain(500);
    chk("clean_locked", locked, 1);
    chk("clean_frame_cnt", frame_cnt, 3);
    chk("clean_coord_err", coord_err_cnt, 0);
    chk("clean_pix_err", pix_err_cnt, 0);
    chk("clean_done_pulses", done_pulses, 3);
    chk("clean_period", frame_period, 24'h000008);

    push_frame(0, 7, -1, -1, 24'h0, 24'hFFFFF0);
    push_frame(0, 7, -1, -1, 24'h0, 24'h000010);
    drain(500);
    chk("wrap_period", frame_period, 24'h000020);
    chk("wrap_frame_cnt", frame_cnt, 5);

    push_frame(0, 7, 2, -1, 24'h0, 24'h000100);
    drain(500);
    chk("drop_coord_err", coord_err_cnt, 1);
    chk("drop_locked", locked, 0);
    src_q.push_back({1'b0, mk(12'd0, 12'd0, 24'h000200)});
    drain(500);
    chk("relock_locked", locked, 1);
    chk("relock_frame_cnt", frame_cnt, 0);
    push_frame(1, 7, -1, -1, 24'h0, 24'h000200);
    drain(500);
    chk("relock_frame_cnt1", frame_cnt, 1);
    chk("relock_coord_err", coord_err_cnt, 1);

    push_frame(0, 7, -1, 5, 24'h000100, 24'h000300);
    drain(500);
    chk("gbad_pix_err", pix_err_cnt, 1);
    chk("gbad_coord_err", coord_err_cnt, 1);
    chk("gbad_locked", locked, 1);
    chk("gbad_np_pix_err", np_pix_err_cnt, 0);

    clr_req = 1'b1;
    drain(50);
    chk("clr_pix_err", pix_err_cnt, 0);
    chk("clr_coord_err", coord_err_cnt, 0);
    for (int i = 0; i < 70000; i++) begin
      w = mk(12'((i % NPIX) % NH), 12'((i % NPIX) / NH), 24'h400000 + 24'(i));
      w[71:64] = w[71:64] ^ 8'h80;
      src_q.push_back({1'b0, w});
    end
    drain(80000);
    chk("sat_pix_err", pix_err_cnt, 16'hFFFF);
    chk("sat_np_pix_err", np_pix_err_cnt, 0);
    w = mk(12'd0, 12'd0, 24'h500000);
    w[71:64] = w[71:64] ^ 8'h80;
    src_q.push_back({1'b1, w});
    push_frame(1, 7, -1, -1, 24'h0, 24'h500000);
    drain(500);
    chk("satclr_pix_err", pix_err_cnt, 0);
    chk("satclr_locked", locked, 1);

    push_frame(0, 3, -1, -1, 24'h0, 24'h600000);
    drain(500);
    chk("midreset_pre_locked", locked, 1);
    do_reset();
    push_frame(4, 7, -1, -1, 24'h0, 24'h600000);
    push_frame(0, 7, -1, -1, 24'h0, 24'h600008);
    drain(500);
    chk("midreset_coord_err", coord_err_cnt, 0);
    chk("midreset_frame_cnt", frame_cnt, 1);
    chk("midreset_locked", locked, 1);

    stall_pct = 30;
    g_ts = 24'hFFFF00;
    for (int f = 0; f < 300; f++) begin
      first = 0; drop = -1; bad = -1;
      mask = 24'(1) << $urandom_range(23);
      case ($urandom_range(19))
        0, 1:    drop = $urandom_range(7);
        2, 3:    bad = $urandom_range(7);
        4:       first = $urandom_range(7, 1);
        default: ;
      endcase
      push_frame(first, 7, drop, bad, mask, g_ts);
      g_ts = g_ts + 24'd8 + 24'($urandom_range(5));
      if ($urandom_range(39) == 0) g_ts = 24'($urandom);
      if ($urandom_range(29) == 0) clr_req = 1'b1;
      for (int n = 0; n < 1000 && src_q.size() > 12; n++) @(posedge clk);
    end
    drain(5000);
    chk("sb_empty", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hdmi_frame_checker.md
HDMI_FRAME_CHECKER -- requirements
Module: hdmi_frame_checker

Interface
REQ-001 SHALL have parameter H_TOTAL, default 12'd1920, active pixels per line.
REQ-002 SHALL have parameter V_TOTAL, default 12'd1080, active lines per frame.
REQ-003 SHALL have parameter PATTERN_EN, default 1'b1, enables pixel-value check against the test pattern.
REQ-004 SHALL have port clk  input  1  system clock; all logic is synchronous to it.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port fifo_dout  input  72  capture FIFO word {R[71:64],G[63:56],B[55:48],h[47:36],v[35:24],ts[23:0]}.
REQ-007 SHALL have port fifo_empty  input  1  capture FIFO empty.
REQ-008 SHALL have port fifo_valid  input  1  fifo_dout valid (FWFT off; one cycle after rd_en).
REQ-009 SHALL have port fifo_rd_en  output  1  capture FIFO read enable.
REQ-010 SHALL have port stat_clr  input  1  synchronous clear of error counters.
REQ-011 SHALL have port locked  output  1  checker aligned to a frame start.
REQ-012 SHALL have port frame_cnt  output  16  completed frames since lock.
REQ-013 SHALL have port coord_err_cnt  output  16  coordinate sequence errors, saturating.
REQ-014 SHALL have port pix_err_cnt  output  16  pixel-value mismatches, saturating.
REQ-015 SHALL have port frame_period  output  24  ts delta between the last two frame starts.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse on final pixel of a frame.

Function
REQ-017 SHALL drive fifo_rd_en = ~fifo_empty every cycle; no backpressure, one word per cycle max.
REQ-018 SHALL process a word only in the cycle fifo_valid=1; fifo_valid=0 cycles leave all state unchanged.
REQ-019 SHALL implement states HUNT, CHECK, RESYNC.
REQ-020 HUNT: discards words until h=0 and v=0; then latches ts as frame start, sets exp_h=1, exp_v=0, moves to CHECK, asserts locked next cycle.
REQ-021 CHECK: compares word h/v to exp_h/exp_v; on match advances exp_h; at exp_h=H_TOTAL-1 wraps exp_h to 0 and increments exp_v.
REQ-022 CHECK: word with h=H_TOTAL-1, v=V_TOTAL-1 matching SHALL pulse frame_done, increment frame_cnt (wrapping), set exp_h=0, exp_v=0.
REQ-023 CHECK: word h=0,v=0 SHALL load frame_period = ts - start_ts (mod 2^24) and latch ts as new start; first frame after lock leaves frame_period unchanged.
REQ-024 CHECK: h/v mismatch SHALL increment coord_err_cnt once, go to RESYNC, deassert locked next cycle.
REQ-025 RESYNC SHALL behave as HUNT (including when the mismatching word itself is h=0,v=0: it re-locks on that word without a second error).
REQ-026 Pattern check, when PATTERN_EN=1 and state CHECK with coordinates matching: expected R=h[7:0], G=v[7:0], B=h[7:0]^v[7:0]; any mismatch increments pix_err_cnt.
REQ-027 Error counters SHALL saturate at 16'hFFFF; stat_clr zeroes them, with stat_clr taking priority over a simultaneous increment.
REQ-028 frame_cnt SHALL clear on entering HUNT/RESYNC lock (i.e. on each new lock).
REQ-029 Arithmetic on exp_h/exp_v SHALL be 12-bit unsigned; ts subtraction 24-bit modular.

Reset
REQ-030 On rst_n=0: state HUNT, fifo_rd_en=0, locked=0, frame_done=0, all counters and frame_period 0, exp_h/exp_v 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame; after release the block hunts for the next h=0,v=0.

Structure
REQ-032 A shared package SHALL hold the state encoding and the 72-bit word field offsets (R/G/B/H/V/TS lsb/msb).
REQ-033 Saturating 16-bit counter SHALL be a sub-module sat_cnt16 (inc, clr, q), instantiated twice.

Verification
REQ-034 Reset then 3 clean 4x2 frames (H_TOTAL=4,V_TOTAL=2), correct pattern -> locked=1, frame_cnt=3, both error counts 0, three frame_done pulses.
REQ-035 Stream starts mid-frame at h=2,v=1 -> words discarded until h=0,v=0, locked rises one cycle after that word, coord_err_cnt=0.
REQ-036 Drop pixel h=2 on v=0 -> coord_err_cnt=1, locked falls, re-locks on next frame start, frame_cnt restarts at 0.
REQ-037 Corrupt G on one pixel -> pix_err_cnt=1, coord_err_cnt=0, locked stays 1; with PATTERN_EN=0 -> pix_err_cnt=0.
REQ-038 Frame starts ts=24'hFFFFF0 then 24'h000010 -> frame_period=24'h000020.
REQ-039 Force 70000 pixel errors, then stat_clr coincident with error -> count holds 16'hFFFF, then reads 0.
